mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage; produces HI/LO results.
//  The decoder's MULT/MULTU/DIV/DIVU controls drive it. Radix-2: one bit per cycle, with a

---
 rtl/mdu_iter_pkg.sv | 18 +
 rtl/mdu_iter_step.sv | 34 +++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 tb/tb_mdu_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the operation codes and the FSM states.
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the shared {upper, lower} register of width 2*WIDTH+1.
// Multiply: conditional add then shift right. Divide: shift left, then restoring trial subtract.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH:0]   i_p,
    input  logic [WIDTH-1:0]   i_m,
    output logic [2*WIDTH:0]   o_p
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc;
    logic [2*WIDTH:0] w_sh;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_sum  = i_p[2*WIDTH:WIDTH] + {1'b0, i_m};
        w_acc  = i_p[0] ? w_sum : i_p[2*WIDTH:WIDTH];
        w_sh   = {i_p[2*WIDTH-1:0], 1'b0};
        // Extra top bit of the difference acts as the borrow flag.
        w_diff = {1'b0, w_sh[2*WIDTH:WIDTH]} - {2'b00, i_m};
        if (i_is_div) begin
            if (!w_diff[WIDTH+1]) begin
                o_p = {w_diff[WIDTH:0], w_sh[WIDTH-1:1], 1'b1};
            end else begin
                o_p = w_sh;
            end
        end else begin
            o_p = {1'b0, w_acc, i_p[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with start/busy/done handshake and cancel.
// Operands are processed as magnitudes; signs are applied in FIX.
//   state | meaning
//   IDLE  | waiting for start; busy low
//   CALC  | one iteration per edge, counter counts WIDTH..1
//   FIX   | apply signs, write hi/lo, pulse done on leaving
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    mdu_state_e       r_state;
    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2*WIDTH:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_div;
    logic             w_signed;
    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [2*WIDTH:0] w_p_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    assign w_is_div = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
    assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    assign w_accept = (r_state == MDU_IDLE) && i_start && !i_cancel;
    assign w_b_zero = (i_b == '0);
    // MIN negates to itself, which is exactly its unsigned magnitude.
    assign w_a_abs  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_abs  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_prod   = r_neg_q ? -r_p[2*WIDTH-1:0] : r_p[2*WIDTH-1:0];
    assign w_q      = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r      = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_p      (r_p),
        .i_m      (r_m),
        .o_p      (w_p_step)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_is_div && w_b_zero) ? MDU_FIX : MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (i_cancel) begin
                    w_state_nxt = MDU_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = MDU_FIX;
                end
            end
            MDU_FIX:  w_state_nxt = MDU_IDLE;
            default:  w_state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_neg_r  <= w_signed && i_a[WIDTH-1];
                        r_dz     <= w_is_div && w_b_zero;
                        r_cnt    <= CNT_W'(WIDTH);
                        if (w_is_div) begin
                            r_p <= {{(WIDTH+1){1'b0}}, (w_b_zero ? i_a : w_a_abs)};
                            r_m <= w_b_abs;
                        end else begin
                            r_p <= {{(WIDTH+1){1'b0}}, w_b_abs};
                            r_m <= w_a_abs;
                        end
                    end
                end
                MDU_CALC: begin
                    if (!i_cancel) begin
                        r_p   <= w_p_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                MDU_FIX: begin
                    if (!i_cancel) begin
                        r_done <= 1'b1;
                        if (r_dz) begin
                            r_hi <= r_p[WIDTH-1:0];
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_r;
                            r_lo <= w_q;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != MDU_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32: vector table plus abort, reset and back-to-back sequences.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cancel;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_cancel (cancel),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, input int budget);
        lat = 0;
        while (lat < budget && done !== 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        int lat2;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1};
        vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
        vecs[11] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 33};
        vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vecs[13] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[14] = '{2'b11, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 33};
        vecs[15] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);

        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy after accept", i), 64'(busy), 64'd1);
            wait_done(lat, 60);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d busy in done cycle", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            @(negedge clk);
            chk($sformatf("v%0d done one cycle", i), 64'(done), 64'd0);
        end

        // cancel on the 10th CALC cycle; hi/lo must keep 7/2 result
        launch(2'b11, 32'd7, 32'd2);
        wait_done(lat, 60);
        chk("pre-cancel lo", 64'(lo), 64'd3);
        @(negedge clk);
        launch(2'b01, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        chk("busy before cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        chk("cancel hi", 64'(hi), 64'd1);
        chk("cancel lo", 64'(lo), 64'd3);
        watch_no_done("cancel no done", 40);
        chk("cancel hi held", 64'(hi), 64'd1);

        // start while busy is ignored and not queued
        launch(2'b01, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, 60);
        chk("busy-start latency", 64'(lat), 64'd28);
        chk("busy-start hi", 64'(hi), 64'd0);
        chk("busy-start lo", 64'(lo), 64'd15);
        watch_no_done("busy-start not queued", 40);

        // cancel and start together in IDLE: start dropped
        op = 2'b11; a = 32'd9; b = 32'd0; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel+start busy", 64'(busy), 64'd0);
        watch_no_done("cancel+start no done", 10);
        chk("cancel+start lo held", 64'(lo), 64'd15);

        // cancel alone in IDLE does nothing
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("idle cancel busy", 64'(busy), 64'd0);
        chk("idle cancel lo", 64'(lo), 64'd15);

        // async reset mid-CALC
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("post-rst no done", 40);

        // back-to-back: start held through the done cycle
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat, 60);
        chk("b2b first latency", 64'(lat), 64'd33);
        chk("b2b first lo", 64'(lo), 64'd15);
        op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b second accepted", 64'(busy), 64'd1);
        wait_done(lat2, 60);
        chk("b2b done spacing", 64'(lat2 + 1), 64'(W + 2));
        chk("b2b second hi", 64'(hi), 64'd2);
        chk("b2b second lo", 64'(lo), 64'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
